// File: rtl/wire_delay_pkg.sv
// Shared helpers for the wire delay line: occupancy counter width and
// a parameter legality check used at elaboration time.
package wire_delay_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit params_ok(input int width, input int depth, input int channels);
    return (width >= 1) && (depth >= 1) && (channels >= 1);
  endfunction

endpackage

// File: rtl/wire_delay_stage.sv
// One pipeline stage: valid bit plus a data word. clr drops the valid
// but keeps the data; hold freezes both.
module wire_delay_stage
  import wire_delay_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold_i,
  input  logic          clr_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (!hold_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/wire_delay_line.sv
// Fixed-latency multi-lane register pipeline with stall, flush and a
// combinational bypass; also exports inverted data and live occupancy.
module wire_delay_line
  import wire_delay_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  output logic                        in_ready,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        bypass,
  output logic                        out_valid,
  output logic [CHANNELS*WIDTH-1:0]   out_data,
  output logic [CHANNELS*WIDTH-1:0]   out_data_n,
  output logic [cnt_w(DEPTH)-1:0]     occupancy
);

  localparam int DW = CHANNELS * WIDTH;
  localparam int CW = cnt_w(DEPTH);

  if (!params_ok(WIDTH, DEPTH, CHANNELS)) begin : g_bad_params
    $error("wire_delay_line: WIDTH, DEPTH and CHANNELS must all be >= 1");
  end

  logic [DEPTH-1:0] stage_valid;
  logic [DW-1:0]    stage_data [DEPTH];
  logic             stage_clr;
  logic             stage_hold;

  // Flush and bypass both empty the pipe; clr outranks hold inside a stage.
  assign stage_clr  = flush | bypass;
  assign stage_hold = stall;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic          chain_valid;
    logic [DW-1:0] chain_data;

    if (gi == 0) begin : g_entry
      assign chain_valid = in_valid;
      assign chain_data  = in_data;
    end else begin : g_link
      assign chain_valid = stage_valid[gi-1];
      assign chain_data  = stage_data[gi-1];
    end

    wire_delay_stage #(.DW(DW)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .hold_i  (stage_hold),
      .clr_i   (stage_clr),
      .valid_i (chain_valid),
      .data_i  (chain_data),
      .valid_o (stage_valid[gi]),
      .data_o  (stage_data[gi])
    );
  end

  assign in_ready   = bypass | (!stall && !flush);
  assign out_valid  = bypass ? in_valid : stage_valid[DEPTH-1];
  assign out_data   = bypass ? in_data  : stage_data[DEPTH-1];
  assign out_data_n = ~out_data;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + CW'(stage_valid[i]);
    end
  end

endmodule
